// File: rtl/ifu_line_fill.sv
// ---------------------------------------------------------------------------
// ifu_line_fill
//   Miss-fill engine between the instruction cache miss port and a word-wide
//   instruction memory. A line tag is captured from the cache, one word read is
//   issued per word of the line (in ascending order), the returned words are
//   assembled into a line, and tag + line are handed back as a one-cycle pulse.
//
// Ports
//   Clock              in   clock, rising edge
//   Rst                in   asynchronous reset, active-low
//   fill_reqTagIn      in   tag of the missing line
//   fill_reqValidIn    in   miss request (level)
//   fill_rspTagOut     out  tag of the returned line
//   fill_rspLineOut    out  assembled line, word i at [i*WORD_WIDTH +: WORD_WIDTH]
//   fill_rspValidOut   out  one-cycle response pulse
//   fill_busyOut       out  engine not idle
//   mem_rdReqOut       out  word read request
//   mem_rdAddrOut      out  word-aligned byte address of the read
//   mem_rdReadyIn      in   memory accepts the request when req & ready
//   mem_rdDataIn       in   read data, returned in request order
//   mem_rdDataValidIn  in   read data valid
// ---------------------------------------------------------------------------
module ifu_line_fill #(
    parameter int ADDR_WIDTH     = 32,
    parameter int OFFSET_WIDTH   = 4,
    parameter int LINE_WIDTH     = 128,
    parameter int WORD_WIDTH     = 32,
    parameter int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH,
    parameter int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic [TAG_WIDTH-1:0]  fill_reqTagIn,
    input  logic                  fill_reqValidIn,
    output logic [TAG_WIDTH-1:0]  fill_rspTagOut,
    output logic [LINE_WIDTH-1:0] fill_rspLineOut,
    output logic                  fill_rspValidOut,
    output logic                  fill_busyOut,
    output logic                  mem_rdReqOut,
    output logic [ADDR_WIDTH-1:0] mem_rdAddrOut,
    input  logic                  mem_rdReadyIn,
    input  logic [WORD_WIDTH-1:0] mem_rdDataIn,
    input  logic                  mem_rdDataValidIn
);

    localparam int IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int CNT_W  = IDX_W + 1;
    localparam int BYTE_W = $clog2(WORD_WIDTH / 8);

    localparam logic [CNT_W-1:0] WPL_CNT  = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Core state
    state_t                r_state;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [CNT_W-1:0]      r_issue_cnt;
    logic [CNT_W-1:0]      r_rcv_cnt;
    logic [LINE_WIDTH-1:0] r_line;

    // Registered outputs
    logic                  r_rsp_valid;
    logic [TAG_WIDTH-1:0]  r_rsp_tag;
    logic [LINE_WIDTH-1:0] r_rsp_line;
    logic                  r_busy;
    logic                  r_rd_req;
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    // Next-state values
    state_t                w_state_nxt;
    logic [TAG_WIDTH-1:0]  w_tag_nxt;
    logic [CNT_W-1:0]      w_issue_nxt;
    logic [CNT_W-1:0]      w_rcv_nxt;
    logic [LINE_WIDTH-1:0] w_line_nxt;
    logic [IDX_W-1:0]      w_rcv_idx;
    logic                  w_rd_req_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_addr_nxt;

    assign w_rcv_idx = r_rcv_cnt[IDX_W-1:0];

    // Outputs are computed from next-state values and registered, so they line
    // up with the state they describe (e.g. first read request in the cycle
    // right after capture, response pulse during the DONE cycle).
    assign w_rd_req_nxt  = (w_state_nxt == ST_FILL) && (w_issue_nxt < WPL_CNT);
    assign w_rd_addr_nxt = {w_tag_nxt, w_issue_nxt[IDX_W-1:0], {BYTE_W{1'b0}}};

    assign fill_rspTagOut   = r_rsp_tag;
    assign fill_rspLineOut  = r_rsp_line;
    assign fill_rspValidOut = r_rsp_valid;
    assign fill_busyOut     = r_busy;
    assign mem_rdReqOut     = r_rd_req;
    assign mem_rdAddrOut    = r_rd_addr;

    // Next-state logic: capture, issue/receive counting and line assembly
    always_comb begin
        w_state_nxt = r_state;
        w_tag_nxt   = r_tag;
        w_issue_nxt = r_issue_cnt;
        w_rcv_nxt   = r_rcv_cnt;
        w_line_nxt  = r_line;
        case (r_state)
            ST_IDLE: begin
                // Returning data is not expected here and is ignored.
                if (fill_reqValidIn) begin
                    w_tag_nxt   = fill_reqTagIn;
                    w_issue_nxt = {CNT_W{1'b0}};
                    w_rcv_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = ST_FILL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                // Issue and receive proceed independently in the same cycle.
                if (r_rd_req && mem_rdReadyIn) begin
                    w_issue_nxt = r_issue_cnt + CNT_W'(1);
                end else begin
                    w_issue_nxt = r_issue_cnt;
                end
                if (mem_rdDataValidIn) begin
                    w_line_nxt[w_rcv_idx*WORD_WIDTH +: WORD_WIDTH] = mem_rdDataIn;
                    w_rcv_nxt = r_rcv_cnt + CNT_W'(1);
                    if (r_rcv_cnt == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_rcv_nxt = r_rcv_cnt;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_state     <= ST_IDLE;
            r_tag       <= {TAG_WIDTH{1'b0}};
            r_issue_cnt <= {CNT_W{1'b0}};
            r_rcv_cnt   <= {CNT_W{1'b0}};
            r_line      <= {LINE_WIDTH{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_tag       <= w_tag_nxt;
            r_issue_cnt <= w_issue_nxt;
            r_rcv_cnt   <= w_rcv_nxt;
            r_line      <= w_line_nxt;
        end
    end

    // Output registers; response tag/line hold their last value between pulses
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_tag   <= {TAG_WIDTH{1'b0}};
            r_rsp_line  <= {LINE_WIDTH{1'b0}};
            r_busy      <= 1'b0;
            r_rd_req    <= 1'b0;
            r_rd_addr   <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_rsp_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_rd_req    <= w_rd_req_nxt;
            if (w_state_nxt == ST_FILL) begin
                r_rd_addr <= w_rd_addr_nxt;
            end
            if (w_state_nxt == ST_DONE) begin
                r_rsp_tag  <= w_tag_nxt;
                r_rsp_line <= w_line_nxt;
            end
        end
    end

endmodule
